// File: rtl/hack_control_if.sv
// Bus bundle between the Hack control unit and its instruction memory, data memory and external ALU.
// The master side is the control unit; the slave side is the memories/ALU environment.
interface hack_control_if;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    logic [14:0] dmem_addr;
    logic [15:0] dmem_rdata;
    logic [15:0] dmem_wdata;
    logic        dmem_we;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_out;
    logic        zr, ng;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_addr, dmem_wdata, dmem_we,
        input  dmem_rdata,
        output alu_x, alu_y, zx, nx, zy, ny, f, no,
        input  alu_out, zr, ng
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_addr, dmem_wdata, dmem_we,
        output dmem_rdata,
        input  alu_x, alu_y, zx, nx, zy, ny, f, no,
        output alu_out, zr, ng
    );
endinterface

// File: rtl/hack_control.sv
// Hack CPU control: FETCH -> (EXEC) -> WB; A-instr takes 2 cycles, C-instr 3, plus one per ack wait cycle.
// Fetch stalls in FETCH with imem_req held until imem_ack; there is no other backpressure.
module hack_control (
    input  logic           clk,
    input  logic           rst_n,
    hack_control_if.master bus,
    output logic [14:0]    pc_out,
    output logic [15:0]    a_out,
    output logic [15:0]    d_out
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_run;
    logic [14:0] r_pc;
    logic [15:0] r_a;
    logic [15:0] r_d;
    logic [15:0] r_ir;
    logic [15:0] r_r;
    logic        r_zr;
    logic        r_ng;

    logic        w_is_c;
    logic        w_fetch;
    logic        w_jump;

    assign w_is_c  = r_ir[15];
    // r_run holds off the very first request until one edge after reset release.
    assign w_fetch = (r_state == S_FETCH) && r_run && bus.imem_ack;
    assign w_jump  = (r_ir[2] & r_ng) | (r_ir[1] & r_zr) | (r_ir[0] & ~r_ng & ~r_zr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_fetch) begin
                    w_next = bus.imem_rdata[15] ? S_EXEC : S_WB;
                end
            end
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_pc  <= '0;
            r_a   <= '0;
            r_d   <= '0;
            r_ir  <= '0;
            r_r   <= '0;
            r_zr  <= 1'b0;
            r_ng  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_fetch) begin
                r_ir <= bus.imem_rdata;
            end
            if (r_state == S_EXEC) begin
                r_r  <= bus.alu_out;
                r_zr <= bus.zr;
                r_ng <= bus.ng;
            end
            if (r_state == S_WB) begin
                if (!w_is_c) begin
                    r_a  <= r_ir;
                    r_pc <= r_pc + 15'd1;
                end else begin
                    // Jump target and M address both use A as it was before this WB.
                    if (r_ir[5]) r_a <= r_r;
                    if (r_ir[4]) r_d <= r_r;
                    r_pc <= w_jump ? r_a[14:0] : (r_pc + 15'd1);
                end
            end
        end
    end

    assign bus.imem_req   = r_run && (r_state == S_FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_addr  = r_a[14:0];
    assign bus.dmem_wdata = r_r;
    assign bus.dmem_we    = (r_state == S_WB) && w_is_c && r_ir[3];

    assign bus.alu_x = r_d;
    assign bus.alu_y = r_ir[12] ? bus.dmem_rdata : r_a;
    assign {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = w_is_c ? r_ir[11:6] : 6'b0;

    assign pc_out = r_pc;
    assign a_out  = r_a;
    assign d_out  = r_d;

endmodule

// File: tb/tb_hack_control.sv
// Bench for hack_control: drives fetches with random ack delay, models memories and the ALU,
// and compares each retired instruction against an instruction-level reference model.
module tb_hack_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] pc_out;
    logic [15:0] a_out;
    logic [15:0] d_out;

    hack_control_if bus();

    hack_control dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc_out (pc_out),
        .a_out  (a_out),
        .d_out  (d_out)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // External Hack ALU: returns {zr, ng, out}.
    function automatic logic [17:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] a, b, o;
        a = c[5] ? 16'h0 : x;
        if (c[4]) a = ~a;
        b = c[3] ? 16'h0 : y;
        if (c[2]) b = ~b;
        o = c[1] ? (a + b) : (a & b);
        if (c[0]) o = ~o;
        return {(o == 16'h0), o[15], o};
    endfunction

    function automatic logic [15:0] mem_init(input int i);
        logic [15:0] v;
        v = 16'(i) * 16'h9E37;
        return v ^ 16'h5A5A;
    endfunction

    logic [15:0] dmem [0:32767];
    int          wr_total = 0;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;

    assign bus.dmem_rdata = dmem[bus.dmem_addr];
    assign {bus.zr, bus.ng, bus.alu_out} =
        alu(bus.alu_x, bus.alu_y, {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});

    initial begin
        for (int i = 0; i < 32768; i++) dmem[i] = mem_init(i);
        forever begin
            @(posedge clk);
            if (bus.dmem_we === 1'b1) begin
                wr_total++;
                wr_addr = bus.dmem_addr;
                wr_data = bus.dmem_wdata;
                dmem[bus.dmem_addr] = bus.dmem_wdata;
            end
        end
    end

    // Reference architectural state
    logic [14:0] m_pc;
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [15:0] m_mem [0:32767];

    task automatic run(input logic [15:0] ins, input int dly);
        int          base, cyc, exp_cyc, exp_we;
        logic [17:0] res;
        logic [15:0] o, old_a;
        logic        z, n, j;
        logic [14:0] ea;
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        base = wr_total;
        for (int i = 0; i < dly; i++) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 16'($urandom);
            @(posedge clk); @(negedge clk);
            chk("wait_req", 32'(bus.imem_req), 32'd1);
            chk("wait_pc", 32'(pc_out), 32'(m_pc));
            chk("wait_a", 32'(a_out), 32'(m_a));
            chk("wait_d", 32'(d_out), 32'(m_d));
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = ins;
        @(posedge clk); @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        cyc = 1;
        while (bus.imem_req !== 1'b1 && cyc < 8) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end

        exp_we = 0;
        ea     = '0;
        o      = '0;
        if (!ins[15]) begin
            exp_cyc = 2;
            m_a     = ins;
            m_pc    = m_pc + 15'd1;
        end else begin
            exp_cyc = 3;
            res   = alu(m_d, ins[12] ? m_mem[m_a[14:0]] : m_a, ins[11:6]);
            z     = res[17];
            n     = res[16];
            o     = res[15:0];
            old_a = m_a;
            if (ins[3]) begin
                exp_we = 1;
                ea = old_a[14:0];
                m_mem[ea] = o;
            end
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
            j    = (ins[2] & n) | (ins[1] & z) | (ins[0] & ~n & ~z);
            m_pc = j ? old_a[14:0] : (m_pc + 15'd1);
        end

        chk("latency", 32'(cyc), 32'(exp_cyc));
        chk("pc", 32'(pc_out), 32'(m_pc));
        chk("a", 32'(a_out), 32'(m_a));
        chk("d", 32'(d_out), 32'(m_d));
        chk("we_count", 32'(wr_total - base), 32'(exp_we));
        if (exp_we == 1) begin
            chk("wr_addr", 32'(wr_addr), 32'(ea));
            chk("wr_data", 32'(wr_data), 32'(o));
        end
    endtask

    int base0;

    initial begin
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0;
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
        for (int i = 0; i < 32768; i++) m_mem[i] = mem_init(i);

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_d", 32'(d_out), 32'd0);
        chk("rst_ctl", 32'({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}), 32'd0);

        // An ack present on the first edge after release must not be taken.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hFFFF;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", 32'(bus.imem_addr), 32'd0);
        bus.imem_ack = 1'b0;

        base0 = wr_total;
        run(16'h0005, 0);
        run(16'hEC10, 0);
        chk("dA_pc", 32'(pc_out), 32'd2);
        chk("dA_a", 32'(a_out), 32'd5);
        chk("dA_d", 32'(d_out), 32'd5);
        chk("dA_nowr", 32'(wr_total - base0), 32'd0);

        run(16'h0064, 0);
        run(16'hEC10, 1);
        run(16'h0007, 2);
        run(16'hE308, 0);
        chk("mD_addr", 32'(wr_addr), 32'd7);
        chk("mD_data", 32'(wr_data), 32'd100);

        run(16'h0005, 0); run(16'hEC10, 0); run(16'h000A, 0); run(16'hE301, 1);
        chk("jgt_pos", 32'(pc_out), 32'd10);
        run(16'h0000, 0); run(16'hEC10, 0); run(16'h000A, 0); run(16'hE301, 0);
        run(16'h0005, 0); run(16'hECD0, 0); run(16'h000A, 0); run(16'hE301, 0);

        run(16'h0003, 0);
        run(16'hEDE8, 0);
        chk("am_mem3", 32'(dmem[3]), 32'd4);
        chk("am_a", 32'(a_out), 32'd4);
        run(16'hEA87, 0);
        chk("jmp_pc", 32'(pc_out), 32'd4);

        run(16'h7FFF, 0);
        run(16'hEA87, 0);
        chk("pc_top", 32'(pc_out), 32'h7FFF);
        run(16'h0001, 3);
        chk("pc_wrap", 32'(pc_out), 32'd0);

        // Reset while M=D sits in EXEC.
        run(16'h0009, 0);
        run(16'hEC10, 0);
        run(16'h0007, 0);
        base0 = wr_total;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hE308;
        @(posedge clk); @(negedge clk);
        bus.imem_rdata = 16'hFFFF;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc_out), 32'd0);
        chk("mid_rst_a", 32'(a_out), 32'd0);
        chk("mid_rst_d", 32'(d_out), 32'd0);
        chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
        chk("mid_rst_we", 32'(bus.dmem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", 32'(bus.imem_addr), 32'd0);
        chk("restart_nowr", 32'(wr_total - base0), 32'd0);
        bus.imem_ack = 1'b0;
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;

        repeat (200) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 1) == 0) ins[15] = 1'b0;
            else                          ins[15] = 1'b1;
            run(ins, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
